// File: rtl/common_dffram_fifo.sv
// Synchronous FIFO with first-word fall-through. Entries live in a small flop RAM.
// Optional macro COMMON_DFFRAM_FIFO_BYPASS_EN: an empty FIFO forwards wdata straight to rdata.

module common_dffram_2a1we2r #(
  parameter int unsigned          DATA_WIDTH      = 8,
  parameter int unsigned          ADDR_WIDTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  // Per-entry flops; wea acts as a bitwise write mask.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        mem_q[g] <= RAM_RESET_VALUE;
      else if (ena && (addra == ADDR_WIDTH'(g)))
        mem_q[g] <= (mem_q[g] & ~wea) | (dina & wea);
    end
  end

  assign douta = mem_q[addra];
  assign doutb = mem_q[addrb];
endmodule

module common_dffram_fifo #(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [FIFO_DATA_WIDTH-1:0] wdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [FIFO_DATA_WIDTH-1:0] rdata,
  output logic [FIFO_ADDR_WIDTH:0]   count
);
  localparam int unsigned PW = FIFO_ADDR_WIDTH + 1;

  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic                       empty, full, push, pop;
  logic [FIFO_DATA_WIDTH-1:0] ram_doutb, ram_douta_unused;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[FIFO_ADDR_WIDTH-1:0] == rptr_q[FIFO_ADDR_WIDTH-1:0]) &&
                  (wptr_q[FIFO_ADDR_WIDTH] != rptr_q[FIFO_ADDR_WIDTH]);
  assign count  = wptr_q - rptr_q;
  assign wready = !full;

`ifdef COMMON_DFFRAM_FIFO_BYPASS_EN
  logic byp;
  // Empty cycle with a ready consumer: the word passes through, storage untouched.
  assign byp    = empty & wvalid & rready;
  assign rvalid = !empty | wvalid;
  assign rdata  = empty ? wdata : ram_doutb;
  assign push   = wvalid & wready & !byp;
  assign pop    = rvalid & rready & !empty;
`else
  assign rvalid = !empty;
  assign rdata  = ram_doutb;
  assign push   = wvalid & wready;
  assign pop    = rvalid & rready;
`endif

  assign wptr_d = wptr_q + PW'(push);
  assign rptr_d = rptr_q + PW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  common_dffram_2a1we2r #(
    .DATA_WIDTH      (FIFO_DATA_WIDTH),
    .ADDR_WIDTH      (FIFO_ADDR_WIDTH),
    .RAM_RESET_VALUE ('0)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .ena   (push),
    .wea   ({FIFO_DATA_WIDTH{1'b1}}),
    .addra (wptr_q[FIFO_ADDR_WIDTH-1:0]),
    .dina  (wdata),
    .douta (ram_douta_unused),
    .addrb (rptr_q[FIFO_ADDR_WIDTH-1:0]),
    .doutb (ram_doutb)
  );
endmodule

// File: doc/common_dffram_fifo.md
COMMON_DFFRAM_FIFO -- requirements
Module: common_dffram_fifo

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter FIFO_ADDR_WIDTH, default 2, log2 of depth; depth = 2^FIFO_ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wvalid  input  1  producer offers wdata.
REQ-006 SHALL have port wready  output  1  FIFO can accept an entry.
REQ-007 SHALL have port wdata  input  FIFO_DATA_WIDTH  entry to push.
REQ-008 SHALL have port rvalid  output  1  rdata holds the head entry.
REQ-009 SHALL have port rready  input  1  consumer takes the head entry.
REQ-010 SHALL have port rdata  output  FIFO_DATA_WIDTH  head entry, first-word fall-through.
REQ-011 SHALL have port count  output  FIFO_ADDR_WIDTH+1  number of stored entries, 0..depth.

Function
REQ-012 SHALL store entries in one common_dffram_2a1we2r instance: port A = write (addra = write pointer low bits, ena = push, wea all ones, dina = wdata), port B = read (addrb = read pointer low bits, doutb = stored head), all-zero RAM_RESET_VALUE.
REQ-013 SHALL keep write and read pointers of FIFO_ADDR_WIDTH+1 bits each; low bits address storage, MSB is wrap flag; pointers wrap from 2^(FIFO_ADDR_WIDTH+1)-1 to 0.
REQ-014 SHALL define empty = (wptr == rptr); full = (low bits equal, MSBs differ); count = wptr - rptr modulo 2^(FIFO_ADDR_WIDTH+1).
REQ-015 SHALL drive wready = !full, with no combinational dependence on rready.
REQ-016 SHALL define push = wvalid & wready; pop = rvalid & rready; each advances its pointer by one on the same edge.
REQ-017 SHALL, with bypass absent, drive rvalid = !empty and rdata = storage[rptr]; a pushed entry becomes visible on rdata the cycle after its push (latency 1).
REQ-018 SHALL, when full, reject push (wready=0) while allowing pop; count becomes depth-1.
REQ-019 SHALL, when neither empty nor full, accept simultaneous push and pop in one cycle; count unchanged.
REQ-020 SHALL hold rdata stable while rvalid=1 and rready=0.
REQ-021 SHALL never let a push overwrite the entry at rptr while count < depth.

Reset
REQ-022 SHALL, on reset assertion, immediately clear wptr and rptr to 0, regardless of clk.
REQ-023 SHALL present after reset: wready=1, rvalid=0, count=0, rdata=0.
REQ-024 SHALL discard all contents when reset asserts mid-operation, including a push or pop in the same cycle.

Configuration
REQ-025 SHALL honour macro COMMON_DFFRAM_FIFO_BYPASS_EN: when defined, empty FIFO drives rvalid = wvalid and rdata = wdata combinationally.
REQ-026 SHALL, with COMMON_DFFRAM_FIFO_BYPASS_EN defined, treat empty-cycle wvalid & rready as pass-through: no storage write, pointers and count unchanged.
REQ-027 SHALL, with COMMON_DFFRAM_FIFO_BYPASS_EN defined, store an empty-cycle push with rready=0 normally (count 0 -> 1).
REQ-028 SHALL, with COMMON_DFFRAM_FIFO_BYPASS_EN undefined, behave per REQ-017 with no wdata-to-rdata path.

Verification (FIFO_DATA_WIDTH=8, FIFO_ADDR_WIDTH=2)
REQ-029 SHALL cover fill: push 0x11,0x22,0x33,0x44 with rready=0 -> count 1,2,3,4; wready=0 after 4th; 5th wvalid (0x55) ignored; rdata=0x11.
REQ-030 SHALL cover drain: from full, rready=1 for 4 cycles -> rdata 0x11,0x22,0x33,0x44 then rvalid=0, count=0, wready=1.
REQ-031 SHALL cover wrap: 10 cycles, each pushing and popping from count=2 (seed 0xA0,0xA1, push 0xA2..0xAB) -> popped order 0xA0..0xA9, count stays 2, pointers wrap past 7.
REQ-032 SHALL cover full with simultaneous wvalid and rready: pop 0x11, push rejected, count 4 -> 3.
REQ-033 SHALL cover async reset mid-stream at count=3 between clk edges -> count=0, rvalid=0, wready=1 before next edge.
REQ-034 SHALL cover bypass (macro defined): empty, wvalid=1, wdata=0x5A, rready=1 -> rvalid=1, rdata=0x5A same cycle, count remains 0; macro undefined -> rvalid=0 that cycle, count=1 next.
